// File: rtl/accum_status_ctrl.sv
// rtl/accum_status_ctrl.sv - time-base strobe consumer: CPU status, new-data flags, accumulation interrupt
//
// Purpose:
//   Receives the pre_tic / tic / accum strobes from time_base and the per-channel
//   dump pulses from the tracking channels. Presents them to the CPU as sticky
//   status and new-data flags, a level accumulation interrupt that is held until
//   the status register is read, a saturating count of accumulation intervals that
//   arrived while the interrupt was still pending, and a wrapping tic counter.
//
// Optional feature:
//   TIC_TIMESTAMP_EN - when defined, adds a free-running 32-bit cycle counter and
//   the tic_stamp output, which captures that counter on every tic_enable.
//
// Ports:
//   clk             in   1        system clock
//   rst             in   1        synchronous reset, active-high
//   pre_tic_enable  in   1        strobe preceding tic_enable
//   tic_enable      in   1        measurement tic strobe
//   accum_enable    in   1        accumulation-interval strobe
//   dump            in   NUM_CH   per-channel dump pulses
//   status_read     in   1        CPU read of status register (interrupt acknowledge)
//   new_data_read   in   1        CPU read of new_data register
//   accum_int       out  1        accumulation interrupt, level
//   status          out  2        {pre_tic_seen, accum_seen}
//   new_data        out  NUM_CH   sticky per-channel dump flags
//   miss_count      out  MISS_W   saturating count of accum_enable while interrupt pending
//   tic_count       out  24       tic_enable count since reset, wraps
//   tic_stamp       out  32       cycle counter value at last tic (TIC_TIMESTAMP_EN only)

module accum_status_ctrl #(
  parameter int NUM_CH = 12,
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_tic_enable,
  input  logic              tic_enable,
  input  logic              accum_enable,
  input  logic [NUM_CH-1:0] dump,
  input  logic              status_read,
  input  logic              new_data_read,
  output logic              accum_int,
  output logic [1:0]        status,
  output logic [NUM_CH-1:0] new_data,
  output logic [MISS_W-1:0] miss_count,
`ifdef TIC_TIMESTAMP_EN
  output logic [23:0]       tic_count,
  output logic [31:0]       tic_stamp
`else
  output logic [23:0]       tic_count
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  state_t              state_q;
  logic                accum_int_q;
  logic [MISS_W-1:0]   miss_q;

  logic [1:0]          status_q, status_d;
  logic [NUM_CH-1:0]   new_data_q, new_data_d;
  logic [23:0]         tic_count_q, tic_count_d;

  // Interrupt service FSM. accum_int_q is updated alongside the state so it
  // always equals (state_q == ST_PEND) without a decode on the output path.
  // A new accumulation strobe arriving together with the acknowledge keeps the
  // interrupt pending and is not a miss: the CPU will see the fresh event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      accum_int_q <= 1'b0;
      miss_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accum_enable) begin
            state_q     <= ST_PEND;
            accum_int_q <= 1'b1;
          end
        end
        ST_PEND: begin
          if (accum_enable) begin
            accum_int_q <= 1'b1;
            if (!status_read && (miss_q != MISS_MAX)) begin
              miss_q <= miss_q + 1'b1;
            end
          end else if (status_read) begin
            state_q     <= ST_IDLE;
            accum_int_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          accum_int_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as the read-clear survives, so an
  // event coinciding with the CPU read is never lost.
  always_comb begin
    status_d    = status_q;
    status_d[1] = pre_tic_enable | (status_q[1] & ~status_read);
    status_d[0] = accum_enable   | (status_q[0] & ~status_read);
  end

  always_comb begin
    new_data_d = dump | (new_data_read ? '0 : new_data_q);
  end

  always_comb begin
    tic_count_d = tic_count_q;
    if (tic_enable) begin
      tic_count_d = tic_count_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= '0;
      new_data_q  <= '0;
      tic_count_q <= '0;
    end else begin
      status_q    <= status_d;
      new_data_q  <= new_data_d;
      tic_count_q <= tic_count_d;
    end
  end

`ifdef TIC_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] tic_stamp_q;

  // The stamp captures the counter value of the cycle the tic is sampled in,
  // i.e. the value before this edge's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= '0;
      tic_stamp_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (tic_enable) begin
        tic_stamp_q <= cycle_q;
      end
    end
  end

  assign tic_stamp = tic_stamp_q;
`endif

  assign accum_int  = accum_int_q;
  assign status     = status_q;
  assign new_data   = new_data_q;
  assign miss_count = miss_q;
  assign tic_count  = tic_count_q;

endmodule

// File: tb/tb_accum_status_ctrl.sv
// tb/tb_accum_status_ctrl.sv - self-checking bench for accum_status_ctrl

module tb_accum_status_ctrl;

  localparam int NUM_CH   = 12;
  localparam int MISS_W   = 2;
  localparam int MISS_MAX = (1 << MISS_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              pre_tic_enable;
  logic              tic_enable;
  logic              accum_enable;
  logic [NUM_CH-1:0] dump;
  logic              status_read;
  logic              new_data_read;
  logic              accum_int;
  logic [1:0]        status;
  logic [NUM_CH-1:0] new_data;
  logic [MISS_W-1:0] miss_count;
  logic [23:0]       tic_count;
`ifdef TIC_TIMESTAMP_EN
  logic [31:0]       tic_stamp;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, kept as plain integers/flags.
  bit          m_pend;
  int          m_miss;
  bit          m_accum_seen;
  bit          m_pre_seen;
  logic [NUM_CH-1:0] m_nd;
  longint      m_tic;
  longint      m_cyc;
  longint      m_stamp;

  always #5 clk = ~clk;

  accum_status_ctrl #(
    .NUM_CH(NUM_CH),
    .MISS_W(MISS_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pre_tic_enable (pre_tic_enable),
    .tic_enable     (tic_enable),
    .accum_enable   (accum_enable),
    .dump           (dump),
    .status_read    (status_read),
    .new_data_read  (new_data_read),
    .accum_int      (accum_int),
    .status         (status),
    .new_data       (new_data),
    .miss_count     (miss_count),
`ifdef TIC_TIMESTAMP_EN
    .tic_count      (tic_count),
    .tic_stamp      (tic_stamp)
`else
    .tic_count      (tic_count)
`endif
  );

  task automatic idle_inputs();
    rst            = 1'b0;
    pre_tic_enable = 1'b0;
    tic_enable     = 1'b0;
    accum_enable   = 1'b0;
    dump           = '0;
    status_read    = 1'b0;
    new_data_read  = 1'b0;
  endtask

  // One clock: the model consumes the inputs the DUT samples at this edge,
  // then time advances 1 unit so outputs are observed away from the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_miss = 0; m_accum_seen = 0; m_pre_seen = 0;
      m_nd = '0; m_tic = 0; m_cyc = 0; m_stamp = 0;
    end else begin
      if (m_pend && accum_enable && !status_read && m_miss < MISS_MAX) m_miss++;
      if (accum_enable) m_pend = 1;
      else if (status_read) m_pend = 0;
      m_accum_seen = accum_enable   || (m_accum_seen && !status_read);
      m_pre_seen   = pre_tic_enable || (m_pre_seen && !status_read);
      m_nd = dump | (new_data_read ? '0 : m_nd);
      if (tic_enable) begin
        m_tic   = (m_tic + 1) % (64'd1 << 24);
        m_stamp = m_cyc;
      end
      m_cyc = (m_cyc + 1) % (64'd1 << 32);
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; pre_tic_enable = 1'b1; tic_enable = 1'b1; accum_enable = 1'b1;
    dump = '1; status_read = 1'b1; new_data_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if ({accum_int, status, new_data, miss_count, tic_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got int=%b st=%b nd=%h miss=%0d tic=%0d, want all 0",
                 i, accum_int, status, new_data, miss_count, tic_count);
      end
    end
    idle_inputs();
    cycle();
    n_cmp++;
    if ({accum_int, status, new_data, miss_count, tic_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got int=%b st=%b nd=%h miss=%0d tic=%0d, want all 0",
               accum_int, status, new_data, miss_count, tic_count);
    end
  endtask

  task automatic test_accum_ack();
    do_reset();
    accum_enable = 1'b1;
    cycle();
    accum_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (accum_int !== 1'b1 || status !== 2'b01) begin
        n_fail++;
        $display("FAIL accum_pend[%0d]: got int=%b st=%b, want int=1 st=01", i, accum_int, status);
      end
      if (i < 9) cycle();
    end
    status_read = 1'b1;
    cycle();
    status_read = 1'b0;
    n_cmp++;
    if (accum_int !== 1'b0 || status !== 2'b00) begin
      n_fail++;
      $display("FAIL accum_ack: got int=%b st=%b, want int=0 st=00", accum_int, status);
    end
  endtask

  task automatic test_miss_saturate();
    int exp_miss [5] = '{0, 1, 2, 3, 3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      accum_enable = 1'b1;
      cycle();
      accum_enable = 1'b0;
      n_cmp++;
      if (miss_count !== exp_miss[k][MISS_W-1:0] || accum_int !== 1'b1) begin
        n_fail++;
        $display("FAIL miss_sat[%0d]: got miss=%0d int=%b, want miss=%0d int=1",
                 k, miss_count, accum_int, exp_miss[k]);
      end
      repeat (7) cycle();
    end
  endtask

  task automatic test_ack_collision();
    do_reset();
    accum_enable = 1'b1;
    cycle();
    status_read = 1'b1;
    cycle();
    accum_enable = 1'b0;
    status_read  = 1'b0;
    n_cmp++;
    if (accum_int !== 1'b1 || status[0] !== 1'b1 || miss_count !== '0) begin
      n_fail++;
      $display("FAIL ack_collision: got int=%b st0=%b miss=%0d, want int=1 st0=1 miss=0",
               accum_int, status[0], miss_count);
    end
    status_read = 1'b1;
    cycle();
    status_read = 1'b0;
    n_cmp++;
    if (accum_int !== 1'b0 || status !== 2'b00) begin
      n_fail++;
      $display("FAIL ack_after_collision: got int=%b st=%b, want int=0 st=00", accum_int, status);
    end
  endtask

  task automatic test_new_data();
    do_reset();
    dump = 12'h005;
    cycle();
    dump = '0;
    n_cmp++;
    if (new_data !== 12'h005) begin
      n_fail++;
      $display("FAIL new_data_set: got %h, want 005", new_data);
    end
    dump = 12'h004;
    new_data_read = 1'b1;
    cycle();
    idle_inputs();
    n_cmp++;
    if (new_data !== 12'h004) begin
      n_fail++;
      $display("FAIL new_data_collide: got %h, want 004", new_data);
    end
    new_data_read = 1'b1;
    cycle();
    new_data_read = 1'b0;
    n_cmp++;
    if (new_data !== '0) begin
      n_fail++;
      $display("FAIL new_data_clear: got %h, want 000", new_data);
    end
  endtask

  task automatic test_tic_wrap();
    do_reset();
    force dut.tic_count_q = 24'hFFFFFF;
    #1;
    release dut.tic_count_q;
    m_tic = 24'hFFFFFF;
    tic_enable = 1'b1;
    cycle();
    n_cmp++;
    if (tic_count !== 24'h000000) begin
      n_fail++;
      $display("FAIL tic_wrap: got %h, want 000000", tic_count);
    end
    cycle();
    tic_enable = 1'b0;
    n_cmp++;
    if (tic_count !== 24'h000001) begin
      n_fail++;
      $display("FAIL tic_after_wrap: got %h, want 000001", tic_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tic_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dump = 12'(1 << i);
      cycle();
    end
    tic_enable = 1'b0;
    dump = '0;
    n_cmp++;
    if (tic_count !== 24'd5 || new_data !== 12'h01F) begin
      n_fail++;
      $display("FAIL b2b_tic_dump: got tic=%0d nd=%h, want tic=5 nd=01f", tic_count, new_data);
    end
    accum_enable = 1'b1;
    repeat (3) cycle();
    accum_enable = 1'b0;
    n_cmp++;
    if (miss_count !== 2'd2 || accum_int !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accum: got miss=%0d int=%b, want miss=2 int=1", miss_count, accum_int);
    end
  endtask

`ifdef TIC_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    repeat (17) cycle();
    tic_enable = 1'b1;
    cycle();
    tic_enable = 1'b0;
    n_cmp++;
    if (tic_stamp !== 32'd17) begin
      n_fail++;
      $display("FAIL tic_stamp: got %0d, want 17", tic_stamp);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      pre_tic_enable = ($urandom_range(0, 3) == 0);
      tic_enable     = ($urandom_range(0, 1) == 0);
      accum_enable   = ($urandom_range(0, 5) == 0);
      status_read    = ($urandom_range(0, 4) == 0);
      new_data_read  = ($urandom_range(0, 5) == 0);
      dump           = NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
      cycle();
      n_cmp++;
      if (accum_int !== m_pend || status !== {m_pre_seen, m_accum_seen} ||
          new_data !== m_nd || miss_count !== MISS_W'(m_miss) || tic_count !== 24'(m_tic)) begin
        n_fail++;
        $display("FAIL random[%0d]: got int=%b st=%b nd=%h miss=%0d tic=%0d, want int=%b st=%b%b nd=%h miss=%0d tic=%0d",
                 i, accum_int, status, new_data, miss_count, tic_count,
                 m_pend, m_pre_seen, m_accum_seen, m_nd, m_miss, m_tic);
      end
`ifdef TIC_TIMESTAMP_EN
      n_cmp++;
      if (tic_stamp !== 32'(m_stamp)) begin
        n_fail++;
        $display("FAIL random_stamp[%0d]: got %0d, want %0d", i, tic_stamp, m_stamp);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_accum_ack();
    test_miss_saturate();
    test_ack_collision();
    test_new_data();
    test_tic_wrap();
    test_back_to_back();
`ifdef TIC_TIMESTAMP_EN
    test_timestamp();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
